// File: rtl/count_register_pkg.sv
// Active-level constants shared by users of count_register.
// The counter itself does not import this package.
package count_register_pkg;
  localparam logic ASSERT   = 1'b1;
  localparam logic DEASSERT = 1'b0;
endpackage

// File: rtl/count_register.sv
// Loadable up-counter: synchronous reset, parallel load, count enable.
// Priority per edge: rst > load > en > hold; wraps modulo 2^D_WIDTH.
module count_register #(
  parameter int unsigned D_WIDTH = 16,
  parameter int unsigned RST_VAL = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [D_WIDTH-1:0] count_load,
  output logic [D_WIDTH-1:0] count,
  output logic               tc
);

  localparam logic [D_WIDTH-1:0] RST_V = D_WIDTH'(RST_VAL);

  // Declaration initialiser gives simulation a known value before any reset.
  logic [D_WIDTH-1:0] count_q = RST_V;
  logic [D_WIDTH-1:0] count_d;

  // Conditional operators so an X on rst/load/en reaches count unmasked.
  always_comb begin
    count_d = count_q;
    count_d = rst  ? RST_V      :
              load ? count_load :
              en   ? count_q + 1'b1 :
                     count_q;
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;
  assign tc    = &count_q;

endmodule

// File: tb/tb_count_register.sv
// Self-checking bench for count_register: 16-bit, 2-bit and a 4-bit
// instance with a truncated non-zero reset value.
module tb_count_register;
  import count_register_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 16-bit instance
  logic        rst16 = DEASSERT, en16 = DEASSERT, load16 = DEASSERT;
  logic [15:0] cl16 = '0;
  logic [15:0] count16;
  logic        tc16;
  // 2-bit instance
  logic        rst2 = DEASSERT, en2 = DEASSERT, load2 = DEASSERT;
  logic [1:0]  cl2 = '0;
  logic [1:0]  count2;
  logic        tc2;
  // 4-bit instance, RST_VAL 63 truncates to 4'hF
  logic        rst4 = DEASSERT, en4 = DEASSERT, load4 = DEASSERT;
  logic [3:0]  cl4 = '0;
  logic [3:0]  count4;
  logic        tc4;

  logic [15:0] exp16_q[$];
  logic [1:0]  exp2_q[$];

  count_register #(.D_WIDTH(16)) u_c16 (
    .clk(clk), .rst(rst16), .en(en16), .load(load16),
    .count_load(cl16), .count(count16), .tc(tc16)
  );

  count_register #(.D_WIDTH(2)) u_c2 (
    .clk(clk), .rst(rst2), .en(en2), .load(load2),
    .count_load(cl2), .count(count2), .tc(tc2)
  );

  count_register #(.D_WIDTH(4), .RST_VAL(63)) u_c4 (
    .clk(clk), .rst(rst4), .en(en4), .load(load4),
    .count_load(cl4), .count(count4), .tc(tc4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc16(input string tag, input logic r, input logic l, input logic e,
                       input logic [15:0] cl, input logic [15:0] exp);
    logic [15:0] e_v;
    rst16 = r; load16 = l; en16 = e; cl16 = cl;
    exp16_q.push_back(exp);
    @(posedge clk); #1;
    e_v = exp16_q.pop_front();
    check_eq(tag, count16, e_v);
    check_eq({tag, "_tc"}, tc16, (e_v == 16'hFFFF));
  endtask

  task automatic cyc2(input string tag, input logic r, input logic l, input logic e,
                      input logic [1:0] cl, input logic [1:0] exp);
    logic [1:0] e_v;
    rst2 = r; load2 = l; en2 = e; cl2 = cl;
    exp2_q.push_back(exp);
    @(posedge clk); #1;
    e_v = exp2_q.pop_front();
    check_eq(tag, count2, e_v);
    check_eq({tag, "_tc"}, tc2, (e_v == 2'd3));
  endtask

  initial begin
    logic [15:0] m16;
    logic        r, l, e;
    logic [15:0] cl;

    #1;
    check_eq("pre_reset16", count16, 16'h0000);
    check_eq("pre_reset4", count4, 4'hF);
    check_eq("pre_reset4_tc", tc4, 1'b1);

    // 16-bit directed sequence
    cyc16("reset16", ASSERT, ASSERT, ASSERT, 16'hFFFF, 16'h0000);
    cyc16("load1234", DEASSERT, ASSERT, DEASSERT, 16'h1234, 16'h1234);
    cyc16("inc1", DEASSERT, DEASSERT, ASSERT, 16'h0000, 16'h1235);
    cyc16("inc2", DEASSERT, DEASSERT, ASSERT, 16'h0000, 16'h1236);
    cyc16("inc3", DEASSERT, DEASSERT, ASSERT, 16'h0000, 16'h1237);
    cyc16("load_over_en", DEASSERT, ASSERT, ASSERT, 16'h0005, 16'h0005);
    for (int i = 0; i < 4; i++)
      cyc16($sformatf("hold%0d", i), DEASSERT, DEASSERT, DEASSERT, 16'hAAAA, 16'h0005);
    cyc16("load_00fe", DEASSERT, ASSERT, DEASSERT, 16'h00FE, 16'h00FE);
    cyc16("inc_00ff", DEASSERT, DEASSERT, ASSERT, 16'h0000, 16'h00FF);
    cyc16("rst_mid", ASSERT, DEASSERT, ASSERT, 16'h0000, 16'h0000);
    cyc16("resume1", DEASSERT, DEASSERT, ASSERT, 16'h0000, 16'h0001);
    cyc16("resume2", DEASSERT, DEASSERT, ASSERT, 16'h0000, 16'h0002);
    cyc16("load_ffff", DEASSERT, ASSERT, DEASSERT, 16'hFFFF, 16'hFFFF);
    cyc16("wrap16", DEASSERT, DEASSERT, ASSERT, 16'h0000, 16'h0000);
    cyc16("rst_over_load", ASSERT, ASSERT, DEASSERT, 16'h4321, 16'h0000);

    // 16-bit random phase against a behavioural reference
    m16 = 16'h0000;
    for (int i = 0; i < 60; i++) begin
      r  = ($urandom_range(0, 9) == 0);
      l  = ($urandom_range(0, 3) == 0);
      e  = ($urandom_range(0, 1) == 1);
      cl = ($urandom_range(0, 2) == 0) ? 16'hFFFE : 16'($urandom_range(0, 65535));
      if (r)      m16 = 16'h0000;
      else if (l) m16 = cl;
      else if (e) m16 = m16 + 16'd1;
      cyc16($sformatf("rand%0d", i), r, l, e, cl, m16);
    end
    rst16 = DEASSERT; load16 = DEASSERT; en16 = DEASSERT;

    // 2-bit wrap and wait-counter profile
    cyc2("reset2", ASSERT, DEASSERT, DEASSERT, 2'd0, 2'd0);
    cyc2("load3", DEASSERT, ASSERT, DEASSERT, 2'd3, 2'd3);
    cyc2("wrap2", DEASSERT, DEASSERT, ASSERT, 2'd0, 2'd0);
    cyc2("w_inc1", DEASSERT, DEASSERT, ASSERT, 2'd0, 2'd1);
    cyc2("w_inc2", DEASSERT, DEASSERT, ASSERT, 2'd0, 2'd2);
    cyc2("w_inc3", DEASSERT, DEASSERT, ASSERT, 2'd0, 2'd3);
    cyc2("wait_idle0", DEASSERT, ASSERT, ASSERT, 2'd0, 2'd0);
    cyc2("wait_idle1", DEASSERT, ASSERT, ASSERT, 2'd0, 2'd0);
    cyc2("wait_run1", DEASSERT, DEASSERT, ASSERT, 2'd0, 2'd1);
    cyc2("wait_run2", DEASSERT, DEASSERT, ASSERT, 2'd0, 2'd2);
    cyc2("wait_run3", DEASSERT, DEASSERT, ASSERT, 2'd0, 2'd3);
    cyc2("wait_run0", DEASSERT, DEASSERT, ASSERT, 2'd0, 2'd0);
    en2 = DEASSERT;

    // Non-zero, truncated reset value
    en4 = ASSERT;
    @(posedge clk); #1;
    check_eq("rv_wrap", count4, 4'h0);
    check_eq("rv_wrap_tc", tc4, 1'b0);
    rst4 = ASSERT;
    @(posedge clk); #1;
    check_eq("rv_reset", count4, 4'hF);
    check_eq("rv_reset_tc", tc4, 1'b1);
    rst4 = DEASSERT; en4 = DEASSERT;

    check_eq("queue16_drained", exp16_q.size(), 0);
    check_eq("queue2_drained", exp2_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
